byte_fifo_sync: RTL and testbench

- Single-clock, first-word-fall-behind byte FIFO used to queue command and response bytes between a bus frontend and a byte-serial link.
- Storage is a circular buffer addressed by read/write pointers, with full/empty flags.
- Read data is registered: it appears one cycle after a read is accepted, qualified by a registered `valid` strobe. This absorbs the external one-cycle "delayed empty" flop that consumers otherwise add.

---
 rtl/byte_fifo_sync.sv | 159 +++++++++++++++
 tb/tb_byte_fifo_sync.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_fifo_sync.sv
// -----------------------------------------------------------------------------
// byte_fifo_sync
//
// Single-clock byte FIFO that queues command and response bytes between a bus
// frontend and a byte-serial link. Storage is a circular buffer addressed by
// free-running read/write pointers that wrap from DEPTH-1 back to 0.
//
// Read data is registered: a read accepted at one edge presents its byte on
// dout together with a one-cycle valid strobe after that edge. The consumer
// therefore does not need its own "delayed empty" flop.
//
// Ports
//   clk        in   1       clock, all state updates on the rising edge
//   rst        in   1       asynchronous active-high reset
//   wr_en      in   1       write request
//   din        in   WIDTH   write data, sampled with wr_en
//   full       out  1       FIFO holds DEPTH entries
//   rd_en      in   1       read request
//   dout       out  WIDTH   registered read data (holds when no read)
//   valid      out  1       dout carries a newly popped entry this cycle
//   empty      out  1       FIFO holds zero entries
//   count      out  AW+1    current occupancy, 0..DEPTH
//   overflow   out  1       one-cycle pulse, write rejected because full
//   underflow  out  1       one-cycle pulse, read rejected because empty
// -----------------------------------------------------------------------------
module byte_fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             empty,
    output logic [AW:0]      count,
    output logic             overflow,
    output logic             underflow
);

    // Occupancy value that means "completely full", sized to the count.
    localparam logic [AW:0] LP_FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] LP_ZERO_COUNT = {(AW+1){1'b0}};
    localparam logic [AW:0] LP_ONE_COUNT  = (AW+1)'(1);
    localparam logic [AW-1:0] LP_PTR_ONE  = AW'(1);

    // Storage; contents are don't-care after reset, so no reset is applied.
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_empty;
    logic             r_full;
    logic [WIDTH-1:0] r_dout;
    logic             r_valid;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_wr_acc;
    logic             w_rd_acc;
    logic [AW:0]      w_count_nxt;
    logic [AW-1:0]    w_wr_ptr_nxt;
    logic [AW-1:0]    w_rd_ptr_nxt;

    // Accept decisions are made from the pre-edge flags only, so a full FIFO
    // never reuses space freed by a same-cycle read, and an empty FIFO never
    // bypasses a same-cycle write to dout.
    assign w_wr_acc = wr_en & ~r_full;
    assign w_rd_acc = rd_en & ~r_empty;

    // Next occupancy and pointer values from the accepted operations.
    always_comb begin
        w_count_nxt  = r_count;
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;

        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + LP_ONE_COUNT;
            2'b01:   w_count_nxt = r_count - LP_ONE_COUNT;
            default: w_count_nxt = r_count;
        endcase

        if (w_wr_acc) begin
            w_wr_ptr_nxt = r_wr_ptr + LP_PTR_ONE;
        end else begin
            w_wr_ptr_nxt = r_wr_ptr;
        end

        if (w_rd_acc) begin
            w_rd_ptr_nxt = r_rd_ptr + LP_PTR_ONE;
        end else begin
            w_rd_ptr_nxt = r_rd_ptr;
        end
    end

    // Memory write port; only accepted writes touch storage.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers, occupancy and flags. The flags are registered from the next
    // count so they always equal a decode of the registered count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= LP_ZERO_COUNT;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            r_empty  <= (w_count_nxt == LP_ZERO_COUNT);
            r_full   <= (w_count_nxt == LP_FULL_COUNT);
        end
    end

    // Registered read data path; dout holds its value when nothing is popped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout  <= {WIDTH{1'b0}};
            r_valid <= 1'b0;
        end else if (w_rd_acc) begin
            r_dout  <= r_mem[r_rd_ptr];
            r_valid <= 1'b1;
        end else begin
            r_dout  <= r_dout;
            r_valid <= 1'b0;
        end
    end

    // Error pulses for rejected requests; they never affect stored data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= wr_en & r_full;
            r_underflow <= rd_en & r_empty;
        end
    end

    assign full      = r_full;
    assign empty     = r_empty;
    assign count     = r_count;
    assign dout      = r_dout;
    assign valid     = r_valid;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_byte_fifo_sync.sv
// -----------------------------------------------------------------------------
// tb_byte_fifo_sync
//
// Directed self-checking bench for byte_fifo_sync (WIDTH=8, DEPTH=16).
// Inputs are driven and outputs observed on the falling clock edge, so each
// observation reflects the rising edge that sits between two falling edges.
// -----------------------------------------------------------------------------
module tb_byte_fifo_sync;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] din;
    logic       full;
    logic       rd_en;
    logic [7:0] dout;
    logic       valid;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int n_tests;
    int n_fail;

    byte_fifo_sync #(.WIDTH(8), .DEPTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .din       (din),
        .full      (full),
        .rd_en     (rd_en),
        .dout      (dout),
        .valid     (valid),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: the rising edge acts, then we land on the next falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({empty, full, count, valid, dout, overflow, underflow} !== {1'b1, 1'b0, 5'd0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            $display("FAIL reset_state: got e=%0b f=%0b c=%0d v=%0b d=%h ov=%0b un=%0b required e=1 f=0 c=0 v=0 d=00 ov=0 un=0",
                     empty, full, count, valid, dout, overflow, underflow);
            n_fail++;
        end
    endtask

    task automatic test_burst();
        logic [7:0]  bytes [8];
        logic [63:0] word;
        int          npulse;
        int          first_c;
        bytes = '{8'h10, 8'h32, 8'h54, 8'h76, 8'h98, 8'hBA, 8'hDC, 8'hFE};
        word = 64'h0;
        npulse = 0;
        first_c = -1;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            wr_en = (c < 8);
            din   = (c < 8) ? bytes[c] : 8'h00;
            rd_en = ~empty;
            tick();
            if (valid) begin
                if (first_c < 0) first_c = c;
                if (npulse < 8) word[npulse*8 +: 8] = dout;
                npulse++;
            end
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        n_tests++;
        if (npulse !== 8) begin
            $display("FAIL burst_pulses: got %0d required 8", npulse);
            n_fail++;
        end
        n_tests++;
        if (first_c !== 1) begin
            $display("FAIL burst_latency: first valid after %0d cycles required 2", first_c + 1);
            n_fail++;
        end
        n_tests++;
        if (word !== 64'hFEDCBA9876543210) begin
            $display("FAIL burst_order: got %h required FEDCBA9876543210", word);
            n_fail++;
        end
    endtask

    task automatic test_fill_drain();
        do_reset();
        wr_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            din = 8'hA0 + 8'(i);
            tick();
        end
        n_tests++;
        if ({full, empty, count} !== {1'b1, 1'b0, 5'd16}) begin
            $display("FAIL fill_full: got f=%0b e=%0b c=%0d required f=1 e=0 c=16", full, empty, count);
            n_fail++;
        end
        din = 8'hEE;
        tick();
        n_tests++;
        if ({overflow, count, full} !== {1'b1, 5'd16, 1'b1}) begin
            $display("FAIL fill_overflow: got ov=%0b c=%0d f=%0b required ov=1 c=16 f=1", overflow, count, full);
            n_fail++;
        end
        wr_en = 1'b0;
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            n_tests++;
            if ({valid, dout} !== {1'b1, 8'hA0 + 8'(i)}) begin
                $display("FAIL drain_%0d: got v=%0b d=%h required v=1 d=%h", i, valid, dout, 8'hA0 + 8'(i));
                n_fail++;
            end
        end
        n_tests++;
        if ({empty, count, overflow} !== {1'b1, 5'd0, 1'b0}) begin
            $display("FAIL drain_empty: got e=%0b c=%0d ov=%0b required e=1 c=0 ov=0", empty, count, overflow);
            n_fail++;
        end
        tick();
        rd_en = 1'b0;
        n_tests++;
        if ({underflow, valid, dout, count} !== {1'b1, 1'b0, 8'hAF, 5'd0}) begin
            $display("FAIL drain_underflow: got un=%0b v=%0b d=%h c=%0d required un=1 v=0 d=af c=0",
                     underflow, valid, dout, count);
            n_fail++;
        end
        tick();
        n_tests++;
        if (underflow !== 1'b0) begin
            $display("FAIL underflow_pulse_width: got %0b required 0", underflow);
            n_fail++;
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] exp_tail [5];
        exp_tail = '{8'h53, 8'h54, 8'h60, 8'h61, 8'h62};
        do_reset();
        wr_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            din = 8'h50 + 8'(i);
            tick();
        end
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din = 8'h60 + 8'(i);
            tick();
            n_tests++;
            if ({valid, dout, count} !== {1'b1, 8'h50 + 8'(i), 5'd5}) begin
                $display("FAIL simul_%0d: got v=%0b d=%h c=%0d required v=1 d=%h c=5", i, valid, dout, count, 8'h50 + 8'(i));
                n_fail++;
            end
        end
        wr_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_tests++;
            if ({valid, dout} !== {1'b1, exp_tail[i]}) begin
                $display("FAIL simul_tail_%0d: got v=%0b d=%h required v=1 d=%h", i, valid, dout, exp_tail[i]);
                n_fail++;
            end
        end
        // Empty FIFO: only the write happens, no bypass to dout.
        wr_en = 1'b1;
        din   = 8'h77;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        n_tests++;
        if ({underflow, valid, dout, count, empty} !== {1'b1, 1'b0, 8'h62, 5'd1, 1'b0}) begin
            $display("FAIL simul_empty: got un=%0b v=%0b d=%h c=%0d e=%0b required un=1 v=0 d=62 c=1 e=0",
                     underflow, valid, dout, count, empty);
            n_fail++;
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        n_tests++;
        if ({valid, dout, empty} !== {1'b1, 8'h77, 1'b1}) begin
            $display("FAIL simul_empty_read: got v=%0b d=%h e=%0b required v=1 d=77 e=1", valid, dout, empty);
            n_fail++;
        end
    endtask

    task automatic test_full_simultaneous();
        do_reset();
        wr_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            din = 8'(i);
            tick();
        end
        rd_en = 1'b1;
        din   = 8'hEE;
        tick();
        wr_en = 1'b0;
        n_tests++;
        if ({overflow, valid, dout, count, full} !== {1'b1, 1'b1, 8'h00, 5'd15, 1'b0}) begin
            $display("FAIL full_simul: got ov=%0b v=%0b d=%h c=%0d f=%0b required ov=1 v=1 d=00 c=15 f=0",
                     overflow, valid, dout, count, full);
            n_fail++;
        end
        for (int i = 1; i < 16; i++) begin
            tick();
            n_tests++;
            if ({valid, dout} !== {1'b1, 8'(i)}) begin
                $display("FAIL full_simul_drain_%0d: got v=%0b d=%h required v=1 d=%h", i, valid, dout, 8'(i));
                n_fail++;
            end
        end
        tick();
        rd_en = 1'b0;
        n_tests++;
        if ({valid, empty, underflow} !== {1'b0, 1'b1, 1'b1}) begin
            $display("FAIL full_simul_no_reuse: got v=%0b e=%0b un=%0b required v=0 e=1 un=1", valid, empty, underflow);
            n_fail++;
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int r = 0; r < 5; r++) begin
            wr_en = 1'b1;
            for (int i = 0; i < 10; i++) begin
                din = 8'(r * 10 + i) ^ 8'h5A;
                tick();
            end
            wr_en = 1'b0;
            rd_en = 1'b1;
            for (int i = 0; i < 10; i++) begin
                tick();
                n_tests++;
                if ({valid, dout} !== {1'b1, 8'(r * 10 + i) ^ 8'h5A}) begin
                    $display("FAIL wrap_%0d_%0d: got v=%0b d=%h required v=1 d=%h",
                             r, i, valid, dout, 8'(r * 10 + i) ^ 8'h5A);
                    n_fail++;
                end
            end
            rd_en = 1'b0;
        end
        n_tests++;
        if ({count, empty} !== {5'd0, 1'b1}) begin
            $display("FAIL wrap_final: got c=%0d e=%0b required c=0 e=1", count, empty);
            n_fail++;
        end
    endtask

    task automatic test_reset_midop();
        do_reset();
        wr_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            din = 8'hC0 + 8'(i);
            tick();
        end
        wr_en = 1'b0;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        n_tests++;
        if ({count, valid, dout} !== {5'd7, 1'b1, 8'hC0}) begin
            $display("FAIL midop_setup: got c=%0d v=%0b d=%h required c=7 v=1 d=c0", count, valid, dout);
            n_fail++;
        end
        // Short pulse between edges: the reset must act without a clock.
        #1;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({count, empty, valid, full, dout} !== {5'd0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
            $display("FAIL midop_async: got c=%0d e=%0b v=%0b f=%0b d=%h required c=0 e=1 v=0 f=0 d=00",
                     count, empty, valid, full, dout);
            n_fail++;
        end
        rst = 1'b0;
        tick();
        wr_en = 1'b1;
        din   = 8'h3C;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b1;
        tick();
        n_tests++;
        if ({valid, dout, empty} !== {1'b1, 8'h3C, 1'b1}) begin
            $display("FAIL midop_new_byte: got v=%0b d=%h e=%0b required v=1 d=3c e=1", valid, dout, empty);
            n_fail++;
        end
        tick();
        rd_en = 1'b0;
        n_tests++;
        if ({valid, underflow, dout} !== {1'b0, 1'b1, 8'h3C}) begin
            $display("FAIL midop_no_stale: got v=%0b un=%0b d=%h required v=0 un=1 d=3c", valid, underflow, dout);
            n_fail++;
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        din     = 8'h00;
        test_reset();
        test_burst();
        test_fill_drain();
        test_simultaneous();
        test_full_simultaneous();
        test_wrap();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
